// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp codes,
// FSM state encodings, datapath mux selects and the decoded control bundle.
package mips_ctrl_pkg;

    localparam int OPCODE_W = 6;
    localparam int ALUOP_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    // ALUOp codes understood by alu_control_unit
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_FUNC = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 3'b101;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [1:0]         pc_source;
        logic               pc_write;
        logic               pc_write_cond;
        logic               branch_ne;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               illegal;
    } ctrl_t;

endpackage

// File: rtl/main_ctrl_outdec.sv
// Combinational output decoder: registered state (plus opcode and MemReady where
// an output depends on them) to the full datapath control bundle.
module main_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]          state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH2;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: ctrl.illegal = 1'b0;
                    default:                                 ctrl.illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNC;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_OUT;
                ctrl.branch_ne     = (opcode == OP_BNE);
            end
            S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    OP_SLTI: ctrl.alu_op = ALU_SLT;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_IMMWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic, memory
// wait timeout and reset gating of every state-changing enable.
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = mips_ctrl_pkg::OPCODE_W,
    parameter int ALUOP_W  = mips_ctrl_pkg::ALUOP_W,
    parameter int WAIT_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                MemReady,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BranchNe,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                Illegal,
    output logic                BusError
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             in_wait, timeout;
    ctrl_t            ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // MemReady on the final allowed cycle still completes the access normally
    assign timeout = in_wait && !MemReady && (wait_cnt_q == CNT_W'(WAIT_MAX - 1));

    // Count only while stalled; any exit (including timeout back to FETCH) restarts at 0
    assign wait_cnt_d = (in_wait && !MemReady && !timeout) ? wait_cnt_q + 1'b1 : '0;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                         state_d = S_EXEC;
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
                    OP_J:                             state_d = S_JUMP;
                    default:                          state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : (timeout ? S_FETCH : S_MEMRD);
            S_MEMWR:  state_d = (MemReady || timeout) ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            default:  state_d = S_FETCH;
        endcase
    end

    main_ctrl_outdec u_outdec (
        .state     (state_q),
        .opcode    (opcode),
        .mem_ready (MemReady),
        .ctrl      (ctrl)
    );

    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign BranchNe    = ctrl.branch_ne;
    assign IorD        = ctrl.i_or_d;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign PCWrite     = ctrl.pc_write      && !reset;
    assign PCWriteCond = ctrl.pc_write_cond && !reset;
    assign MemRead     = ctrl.mem_read      && !reset;
    assign MemWrite    = ctrl.mem_write     && !reset;
    assign IRWrite     = ctrl.ir_write      && !reset;
    assign RegWrite    = ctrl.reg_write     && !reset;
    assign Illegal     = ctrl.illegal       && !reset;
    assign BusError    = timeout            && !reset;

endmodule
